// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts an instruction, reads an 8x32 register file, issues to an
// external ALU and writes back. Define ALU_ISSUE_CTRL_DIVZERO_CHECK_EN to reject div/rem by zero.
module alu_issue_ctrl #(
    parameter int IMM_W = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [5:0]  alu_operation,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        done,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    localparam logic [5:0] OP_LDI = 6'b100000;
    localparam logic [5:0] OP_BEQ = 6'b100001;
    localparam logic [5:0] OP_BNQ = 6'b100010;
    localparam logic [5:0] OP_DIV = 6'b001010;
    localparam logic [5:0] OP_REM = 6'b001011;
    localparam logic [5:0] OP_MAX = 6'b001011;

    state_t             state;
    logic [5:0]         op_q;
    logic [2:0]         rd_q;
    logic [2:0]         rs_q;
    logic [2:0]         rt_q;
    logic [IMM_W-1:0]   imm_q;
    logic [31:0]        regs [8];
    logic [31:0]        wb_data;
    logic               issue_q;

    logic [31:0]        rs_val;
    logic [31:0]        rt_val;
    logic [31:0]        imm_ext;
    logic [31:0]        opb;
    logic               op_legal;
    logic               op_branch;
    logic               op_writes;
    logic               div_zero;
    logic               issue;
    logic               unused_instr_bits;

    // Bits between the immediate and the rt field carry no meaning.
    assign unused_instr_bits = ^instr[16:IMM_W];

    // Operand fetch and decode; r0 always reads as zero regardless of its storage.
    always_comb begin
        rs_val    = (rs_q == 3'd0) ? 32'd0 : regs[rs_q];
        rt_val    = (rt_q == 3'd0) ? 32'd0 : regs[rt_q];
        imm_ext   = 32'($signed(imm_q));
        opb       = (op_q == OP_LDI) ? imm_ext : rt_val;
        op_branch = (op_q == OP_BEQ) || (op_q == OP_BNQ);
        op_writes = (op_q <= OP_MAX) || (op_q == OP_LDI);
        op_legal  = op_writes || op_branch;
`ifdef ALU_ISSUE_CTRL_DIVZERO_CHECK_EN
        div_zero  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (opb == 32'd0);
`else
        div_zero  = 1'b0;
`endif
        issue     = op_legal && !div_zero;
    end

    // Controller FSM; every output is a register so the ALU sees clean operands for the EXEC cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            instr_ready   <= 1'b1;
            op_q          <= '0;
            rd_q          <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            imm_q         <= '0;
            alu_data1     <= '0;
            alu_data2     <= '0;
            alu_operation <= '0;
            done          <= 1'b0;
            result        <= '0;
            branch_taken  <= 1'b0;
            err           <= 1'b0;
            wb_data       <= '0;
            issue_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q        <= instr[31:26];
                        rd_q        <= instr[25:23];
                        rs_q        <= instr[22:20];
                        rt_q        <= instr[19:17];
                        imm_q       <= instr[IMM_W-1:0];
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    issue_q       <= issue;
                    alu_operation <= issue ? op_q : 6'd0;
                    alu_data1     <= issue ? rs_val : 32'd0;
                    alu_data2     <= issue ? opb : 32'd0;
                    state         <= EXEC;
                end
                EXEC: begin
                    alu_operation <= '0;
                    alu_data1     <= '0;
                    alu_data2     <= '0;
                    done          <= 1'b1;
                    err           <= !issue_q;
                    branch_taken  <= issue_q && op_branch && alu_zero;
                    wb_data       <= alu_result;
                    if (issue_q) begin
                        result <= alu_result;
                    end
                    state <= WB;
                end
                WB: begin
                    if (issue_q && op_writes && (rd_q != 3'd0)) begin
                        regs[rd_q] <= wb_data;
                    end
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: external ALU model, transaction-level reference model checked every
// cycle, plus directed instructions with literal expectations.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [5:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic [31:0] result;
    logic        branch_taken;
    logic        err;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.IMM_W(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .alu_data1(alu_data1),
        .alu_data2(alu_data2),
        .alu_operation(alu_operation),
        .alu_result(alu_result),
        .alu_zero(alu_zero),
        .done(done),
        .result(result),
        .branch_taken(branch_taken),
        .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        z;
        r = 32'd0;
        case (op)
            6'd0:  r = a;
            6'd1:  r = a + b;
            6'd2:  r = a - b;
            6'd3:  r = a & b;
            6'd4:  r = a | b;
            6'd5:  r = a ^ b;
            6'd6:  r = a << b[4:0];
            6'd7:  r = a >> b[4:0];
            6'd8:  r = $unsigned($signed(a) >>> b[4:0]);
            6'd9:  r = a * b;
            6'd10: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            6'd11: r = (b == 32'd0) ? a : a % b;
            6'h20: r = b;
            6'h21: r = a - b;
            6'h22: r = a - b;
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
        if (op == 6'h21) z = (a == b);
        if (op == 6'h22) z = (a != b);
        return {z, r};
    endfunction

    assign {alu_zero, alu_result} = alu_fn(alu_operation, alu_data1, alu_data2);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect computed at acceptance, outputs scheduled by cycle index.
    logic [31:0] mreg [8] = '{default: 32'd0};
    int          cyc = 0;
    int          acc = 0;
    bit          have_pend = 1'b0;
    bit          last_accept = 1'b0;
    bit          p_issue = 1'b0;
    bit          p_bt = 1'b0;
    bit          p_err = 1'b0;
    logic [5:0]  p_op = '0;
    logic [31:0] p_a = '0;
    logic [31:0] p_b = '0;
    logic [31:0] p_res = '0;
    logic [31:0] held_result = '0;

    always @(posedge clock or negedge reset_n) begin : model
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] zr;
        bit          legal;
        bit          branch;
        bit          dz;
        if (!reset_n) begin
            have_pend   = 1'b0;
            last_accept = 1'b0;
            held_result = '0;
            for (int i = 0; i < 8; i++) mreg[i] = '0;
        end else begin
            last_accept = 1'b0;
            if (instr_valid && (!have_pend || cyc >= acc + 3)) begin
                op     = instr[31:26];
                a      = (instr[22:20] == 3'd0) ? 32'd0 : mreg[instr[22:20]];
                if (op == 6'h20) b = {{16{instr[15]}}, instr[15:0]};
                else             b = (instr[19:17] == 3'd0) ? 32'd0 : mreg[instr[19:17]];
                branch = (op == 6'h21) || (op == 6'h22);
                legal  = (op <= 6'd11) || (op == 6'h20) || branch;
`ifdef ALU_ISSUE_CTRL_DIVZERO_CHECK_EN
                dz = ((op == 6'd10) || (op == 6'd11)) && (b == 32'd0);
`else
                dz = 1'b0;
`endif
                p_issue = legal && !dz;
                zr      = alu_fn(op, a, b);
                p_op    = op;
                p_a     = a;
                p_b     = b;
                p_res   = zr[31:0];
                p_bt    = p_issue && branch && zr[32];
                p_err   = !p_issue;
                if (p_issue && !branch && instr[25:23] != 3'd0) mreg[instr[25:23]] = zr[31:0];
                have_pend   = 1'b1;
                acc         = cyc + 1;
                last_accept = 1'b1;
            end
            cyc++;
            if (have_pend && cyc == acc + 2 && p_issue) held_result = p_res;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        bit e_exec;
        bit e_done;
        if (reset_n) begin
            e_exec = have_pend && (cyc == acc + 1) && p_issue;
            e_done = have_pend && (cyc == acc + 2);
            checkOutput("model instr_ready", 32'(instr_ready), 32'(!have_pend || cyc >= acc + 3));
            checkOutput("model done", 32'(done), 32'(e_done));
            checkOutput("model alu_operation", 32'(alu_operation), e_exec ? 32'(p_op) : 32'd0);
            checkOutput("model alu_data1", alu_data1, e_exec ? p_a : 32'd0);
            checkOutput("model alu_data2", alu_data2, e_exec ? p_b : 32'd0);
            checkOutput("model result", result, held_result);
            if (e_done) begin
                checkOutput("model branch_taken", 32'(branch_taken), 32'(p_bt));
                checkOutput("model err", 32'(err), 32'(p_err));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [15:0] imm);
        return {op, rd, rs, rt, 1'b0, imm};
    endfunction

    task automatic applyStimulus(input string name, input logic [31:0] w, input logic [5:0] e_op,
                                 input logic [31:0] e_res, input logic e_bt, input logic e_err);
        bit got;
        got = 1'b0;
        @(negedge clock);
        instr       = w;
        instr_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            got = last_accept;
        end
        instr_valid = 1'b0;
        if (!got) begin
            checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
            return;
        end
        @(negedge clock);
        checkOutput({name, " alu_operation"}, 32'(alu_operation), 32'(e_op));
        @(negedge clock);
        checkOutput({name, " done"}, 32'(done), 32'd1);
        checkOutput({name, " result"}, result, e_res);
        checkOutput({name, " branch_taken"}, 32'(branch_taken), 32'(e_bt));
        checkOutput({name, " err"}, 32'(err), 32'(e_err));
    endtask

    logic [31:0] cont_instr [3];
    logic [31:0] cont_res [3];
    int          seen [3];

    initial begin
        int k;
        int dn;
        int ns;
        bit got;
        $display("[TB] start");
        repeat (3) @(negedge clock);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset branch_taken", 32'(branch_taken), 32'd0);
        checkOutput("reset alu_data1", alu_data1, 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("ready after reset", 32'(instr_ready), 32'd1);

        applyStimulus("ldi r1", mk(6'h20, 3'd1, 3'd0, 3'd0, 16'h0005), 6'h20, 32'h0000_0005, 1'b0, 1'b0);
        applyStimulus("ldi r2", mk(6'h20, 3'd2, 3'd0, 3'd0, 16'hFFFE), 6'h20, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("add r3", mk(6'h01, 3'd3, 3'd1, 3'd2, 16'h0), 6'h01, 32'd3, 1'b0, 1'b0);
        applyStimulus("mov r6=r3", mk(6'h00, 3'd6, 3'd3, 3'd0, 16'h0), 6'h00, 32'd3, 1'b0, 1'b0);
        applyStimulus("beq r1,r1", mk(6'h21, 3'd0, 3'd1, 3'd1, 16'h0), 6'h21, 32'd0, 1'b1, 1'b0);
        applyStimulus("bnq r1,r2", mk(6'h22, 3'd0, 3'd1, 3'd2, 16'h0), 6'h22, 32'd7, 1'b1, 1'b0);
        applyStimulus("illegal", mk(6'h3F, 3'd5, 3'd1, 3'd2, 16'h0), 6'h00, 32'd7, 1'b0, 1'b1);
`ifdef ALU_ISSUE_CTRL_DIVZERO_CHECK_EN
        applyStimulus("div r4", mk(6'h0A, 3'd4, 3'd1, 3'd0, 16'h0), 6'h00, 32'd7, 1'b0, 1'b1);
        applyStimulus("mov r7=r4", mk(6'h00, 3'd7, 3'd4, 3'd0, 16'h0), 6'h00, 32'd0, 1'b0, 1'b0);
`else
        applyStimulus("div r4", mk(6'h0A, 3'd4, 3'd1, 3'd0, 16'h0), 6'h0A, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus("mov r7=r4", mk(6'h00, 3'd7, 3'd4, 3'd0, 16'h0), 6'h00, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif
        applyStimulus("mov r5=r5", mk(6'h00, 3'd5, 3'd5, 3'd0, 16'h0), 6'h00, 32'd0, 1'b0, 1'b0);
        applyStimulus("sub r6", mk(6'h02, 3'd6, 3'd2, 3'd1, 16'h0), 6'h02, 32'hFFFF_FFF9, 1'b0, 1'b0);
        applyStimulus("mov r0=r1", mk(6'h00, 3'd0, 3'd1, 3'd0, 16'h0), 6'h00, 32'd5, 1'b0, 1'b0);
        applyStimulus("mov r6=r0", mk(6'h00, 3'd6, 3'd0, 3'd0, 16'h0), 6'h00, 32'd0, 1'b0, 1'b0);

        // Back-to-back stream with instr_valid held high.
        cont_instr[0] = mk(6'h20, 3'd1, 3'd0, 3'd0, 16'h0007);
        cont_instr[1] = mk(6'h01, 3'd2, 3'd1, 3'd1, 16'h0);
        cont_instr[2] = mk(6'h02, 3'd3, 3'd2, 3'd1, 16'h0);
        cont_res[0] = 32'd7;
        cont_res[1] = 32'd14;
        cont_res[2] = 32'd7;
        k  = 0;
        dn = 0;
        ns = 0;
        @(negedge clock);
        instr       = cont_instr[0];
        instr_valid = 1'b1;
        for (int t = 0; t < 60 && dn < 3; t++) begin
            if (last_accept) begin
                k++;
                if (k < 3) instr = cont_instr[k];
                else       instr_valid = 1'b0;
            end
            if (instr_valid && instr_ready && ns < 3) begin
                seen[ns] = t;
                ns++;
            end
            if (done) begin
                checkOutput("stream result", result, cont_res[dn]);
                dn++;
            end
            @(negedge clock);
        end
        checkOutput("stream completions", 32'(dn), 32'd3);
        checkOutput("stream accepts", 32'(ns), 32'd3);
        if (ns == 3) begin
            checkOutput("stream interval 1", 32'(seen[1] - seen[0]), 32'd4);
            checkOutput("stream interval 2", 32'(seen[2] - seen[1]), 32'd4);
        end

        // Reset in the EXEC cycle of add r5 aborts it.
        @(negedge clock);
        instr       = mk(6'h01, 3'd5, 3'd1, 3'd2, 16'h0);
        instr_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            got = last_accept;
        end
        instr_valid = 1'b0;
        checkOutput("abort accept", 32'(got), 32'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checkOutput("abort done", 32'(done), 32'd0);
            checkOutput("abort alu_operation", 32'(alu_operation), 32'd0);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("ready after abort", 32'(instr_ready), 32'd1);
        applyStimulus("mov r6=r5", mk(6'h00, 3'd6, 3'd5, 3'd0, 16'h0), 6'h00, 32'd0, 1'b0, 1'b0);
        applyStimulus("ldi r1 neg", mk(6'h20, 3'd1, 3'd0, 3'd0, 16'h8000), 6'h20, 32'hFFFF_8000, 1'b0, 1'b0);
        applyStimulus("xor r2=r1^r3", mk(6'h05, 3'd2, 3'd1, 3'd3, 16'h0), 6'h05, 32'hFFFF_8000, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
